// File: rtl/cache_coherence_pkg.sv
// MSI encodings, probe message codes and request opcodes shared by the L1 nodes and the L2 directory.
package cache_coherence_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = 1;
    localparam int unsigned TAG_W     = ADDR_W - IDX_W;
    localparam int unsigned NUM_LINES = 2;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    localparam logic [2:0] PRB_NONE      = 3'b000;
    localparam logic [2:0] PRB_INV       = 3'b001;
    localparam logic [2:0] PRB_FETCH     = 3'b010;
    localparam logic [2:0] PRB_FETCH_INV = 3'b011;

    localparam logic OP_GETS = 1'b0;
    localparam logic OP_GETM = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [1:0]        state;
        logic [DATA_W-1:0] data;
    } line_t;

    // The unused encoding 2'b11 counts as invalid.
    function automatic logic msi_valid(input logic [1:0] st);
        return (st == MSI_S) || (st == MSI_M);
    endfunction

endpackage

// File: rtl/l1_line_array.sv
// Tag/state/data store for the L1: CPU-index and snoop-index read lookups, one write port.
module l1_line_array
    import cache_coherence_pkg::*;
#(
    parameter int unsigned N_LINES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_cpu_idx,
    input  logic [IDX_W-1:0] i_prb_idx,
    output line_t            o_cpu_line,
    output line_t            o_prb_line,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  line_t            i_wline
);

    line_t r_lines [N_LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lines <= '{default: '0};
        end else if (i_we) begin
            r_lines[i_widx] <= i_wline;
        end
    end

    assign o_cpu_line = r_lines[i_cpu_idx];
    assign o_prb_line = r_lines[i_prb_idx];

endmodule

// File: rtl/cache_l1_node.sv
// Private direct-mapped MSI L1 controller: CPU accesses, GetS/GetM requests, victim writebacks
// and L2 probe handling. All outputs are registered.
module cache_l1_node
    import cache_coherence_pkg::*;
#(
    parameter int unsigned CORE_ID = 0,
    parameter int unsigned LINES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuOp,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWrData,
    output logic              cpuReady,
    output logic [DATA_W-1:0] cpuRdData,
    output logic              requestValid,
    output logic [ADDR_W-1:0] addressBypass,
    output logic              operationBypass,
    output logic [DATA_W-1:0] dataBypass,
    output logic              dataWriteBack,
    input  logic [DATA_W-1:0] fetchData,
    input  logic              fetchPresent,
    input  logic [2:0]        interconnectionMessage,
    input  logic [ADDR_W-1:0] probeAddress
);

    // An unsupported CORE_ID or line count collapses the store to zero entries and fails elaboration.
    localparam int unsigned ARRAY_LINES = (CORE_ID < 2 && LINES == NUM_LINES) ? LINES : 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_fill_data;

    logic [IDX_W-1:0]  w_cpu_idx;
    logic [TAG_W-1:0]  w_cpu_tag;
    logic [IDX_W-1:0]  w_prb_idx;
    logic [TAG_W-1:0]  w_prb_tag;
    line_t             w_cpu_line;
    line_t             w_prb_line;
    logic              w_cpu_hit;
    logic              w_prb_hit;
    logic              w_prb_m;

    logic              w_prb_upd;
    logic              w_prb_wb;
    logic [1:0]        w_prb_next;

    logic [1:0]        w_state_nx;
    logic [DATA_W-1:0] w_fill_nx;
    logic              w_ready_nx;
    logic [DATA_W-1:0] w_rd_nx;
    logic              w_rv_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic              w_op_nx;
    logic [DATA_W-1:0] w_dbyp_nx;
    logic              w_wb_nx;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    line_t             w_wline;

    assign w_cpu_idx = cpuAddr[IDX_W-1:0];
    assign w_cpu_tag = cpuAddr[ADDR_W-1:IDX_W];
    assign w_prb_idx = probeAddress[IDX_W-1:0];
    assign w_prb_tag = probeAddress[ADDR_W-1:IDX_W];

    l1_line_array #(
        .N_LINES (ARRAY_LINES)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .i_cpu_idx  (w_cpu_idx),
        .i_prb_idx  (w_prb_idx),
        .o_cpu_line (w_cpu_line),
        .o_prb_line (w_prb_line),
        .i_we       (w_we),
        .i_widx     (w_widx),
        .i_wline    (w_wline)
    );

    assign w_cpu_hit = msi_valid(w_cpu_line.state) && (w_cpu_line.tag == w_cpu_tag);
    assign w_prb_hit = (interconnectionMessage != PRB_NONE) && msi_valid(w_prb_line.state)
                       && (w_prb_line.tag == w_prb_tag);
    assign w_prb_m   = w_prb_hit && (w_prb_line.state == MSI_M);

    // Probe decode: state change on the snooped line and whether it must be written back.
    always_comb begin
        w_prb_upd  = 1'b0;
        w_prb_wb   = 1'b0;
        w_prb_next = MSI_I;
        case (interconnectionMessage)
            PRB_INV: begin
                w_prb_upd = w_prb_hit;
            end
            PRB_FETCH: begin
                w_prb_upd  = w_prb_m;
                w_prb_wb   = w_prb_m;
                w_prb_next = MSI_S;
            end
            PRB_FETCH_INV: begin
                w_prb_upd = w_prb_hit;
                w_prb_wb  = w_prb_m;
            end
            default: ;
        endcase
    end

    // Controller next state. A probe that changes a line owns the write port and, when it
    // writes back, the bus; the CPU side stalls that cycle except for capturing a fill.
    always_comb begin
        w_state_nx = r_state;
        w_fill_nx  = r_fill_data;
        w_ready_nx = 1'b0;
        w_rd_nx    = cpuRdData;
        w_rv_nx    = 1'b0;
        w_addr_nx  = addressBypass;
        w_op_nx    = operationBypass;
        w_dbyp_nx  = dataBypass;
        w_wb_nx    = 1'b0;
        w_we       = 1'b0;
        w_widx     = w_cpu_idx;
        w_wline    = w_cpu_line;

        if (w_prb_upd) begin
            w_we          = 1'b1;
            w_widx        = w_prb_idx;
            w_wline       = w_prb_line;
            w_wline.state = w_prb_next;
        end
        if (w_prb_wb) begin
            w_wb_nx   = 1'b1;
            w_addr_nx = probeAddress;
            w_dbyp_nx = w_prb_line.data;
        end

        case (r_state)
            ST_IDLE: begin
                // cpuReady high means the current access is retiring; do not serve it again.
                if (cpuReq && !cpuReady && !w_prb_upd) begin
                    if (w_cpu_hit && (!cpuOp || w_cpu_line.state == MSI_M)) begin
                        w_ready_nx = 1'b1;
                        if (cpuOp) begin
                            w_we         = 1'b1;
                            w_wline.data = cpuWrData;
                            w_rd_nx      = cpuWrData;
                        end else begin
                            w_rd_nx = w_cpu_line.data;
                        end
                    end else if (!w_cpu_hit && w_cpu_line.state == MSI_M) begin
                        w_state_nx    = ST_WB;
                        w_wb_nx       = 1'b1;
                        w_addr_nx     = {w_cpu_line.tag, w_cpu_idx};
                        w_dbyp_nx     = w_cpu_line.data;
                        w_we          = 1'b1;
                        w_wline.state = MSI_I;
                    end else begin
                        w_state_nx = ST_REQ;
                        w_rv_nx    = 1'b1;
                        w_addr_nx  = cpuAddr;
                        w_op_nx    = cpuOp;
                    end
                end
            end
            ST_WB: begin
                if (!w_prb_wb) begin
                    w_state_nx = ST_REQ;
                    w_rv_nx    = 1'b1;
                    w_addr_nx  = cpuAddr;
                    w_op_nx    = cpuOp;
                end
            end
            ST_REQ: begin
                if (fetchPresent) begin
                    w_state_nx = ST_FILL;
                    w_fill_nx  = fetchData;
                end else if (!w_prb_wb) begin
                    w_rv_nx   = 1'b1;
                    w_addr_nx = cpuAddr;
                    w_op_nx   = cpuOp;
                end
            end
            ST_FILL: begin
                // Upgrades and full fills converge here: a store overwrites the whole byte.
                if (!w_prb_upd) begin
                    w_we          = 1'b1;
                    w_widx        = w_cpu_idx;
                    w_wline.tag   = w_cpu_tag;
                    w_wline.state = cpuOp ? MSI_M : MSI_S;
                    w_wline.data  = cpuOp ? cpuWrData : r_fill_data;
                    w_ready_nx    = 1'b1;
                    w_rd_nx       = cpuOp ? cpuWrData : r_fill_data;
                    w_state_nx    = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_fill_data     <= '0;
            cpuReady        <= 1'b0;
            cpuRdData       <= '0;
            requestValid    <= 1'b0;
            addressBypass   <= '0;
            operationBypass <= OP_GETS;
            dataBypass      <= '0;
            dataWriteBack   <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_fill_data     <= w_fill_nx;
            cpuReady        <= w_ready_nx;
            cpuRdData       <= w_rd_nx;
            requestValid    <= w_rv_nx;
            addressBypass   <= w_addr_nx;
            operationBypass <= w_op_nx;
            dataBypass      <= w_dbyp_nx;
            dataWriteBack   <= w_wb_nx;
        end
    end

endmodule

// File: tb/tb_cache_l1_node.sv
// Directed bench for cache_l1_node: fills, upgrades, victim writebacks, probes and reset mid-miss.
module tb_cache_l1_node;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpuReq;
    logic       cpuOp;
    logic [7:0] cpuAddr;
    logic [7:0] cpuWrData;
    logic       cpuReady;
    logic [7:0] cpuRdData;
    logic       requestValid;
    logic [7:0] addressBypass;
    logic       operationBypass;
    logic [7:0] dataBypass;
    logic       dataWriteBack;
    logic [7:0] fetchData;
    logic       fetchPresent;
    logic [2:0] interconnectionMessage;
    logic [7:0] probeAddress;

    int n_checks = 0;
    int n_errors = 0;

    cache_l1_node #(
        .CORE_ID (0),
        .LINES   (2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cpuReq                 (cpuReq),
        .cpuOp                  (cpuOp),
        .cpuAddr                (cpuAddr),
        .cpuWrData              (cpuWrData),
        .cpuReady               (cpuReady),
        .cpuRdData              (cpuRdData),
        .requestValid           (requestValid),
        .addressBypass          (addressBypass),
        .operationBypass        (operationBypass),
        .dataBypass             (dataBypass),
        .dataWriteBack          (dataWriteBack),
        .fetchData              (fetchData),
        .fetchPresent           (fetchPresent),
        .interconnectionMessage (interconnectionMessage),
        .probeAddress           (probeAddress)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic op, input logic [7:0] addr, input logic [7:0] wd);
        cpuReq    = 1'b1;
        cpuOp     = op;
        cpuAddr   = addr;
        cpuWrData = wd;
    endtask

    task automatic probe(input logic [2:0] msg, input logic [7:0] addr);
        interconnectionMessage = msg;
        probeAddress           = addr;
        tick();
        interconnectionMessage = 3'b000;
    endtask

    // Single-cycle hit: cpuReady on the very next edge, no bus request.
    task automatic hit_access(input string tag, input logic op, input logic [7:0] addr,
                              input logic [7:0] wd, input logic [7:0] exp_rd);
        start(op, addr, wd);
        tick();
        check_val({tag, "_rdy"}, 8'(cpuReady), 8'h01);
        check_val({tag, "_rv"}, 8'(requestValid), 8'h00);
        check_val({tag, "_rd"}, cpuRdData, exp_rd);
        cpuReq = 1'b0;
        tick();
    endtask

    // Answer the outstanding request and wait (bounded) for the access to complete.
    task automatic fill_and_finish(input string tag, input logic [7:0] fdata,
                                   input logic [7:0] exp_rd);
        int n;
        fetchData    = fdata;
        fetchPresent = 1'b1;
        tick();
        fetchPresent = 1'b0;
        fetchData    = 8'h00;
        check_val({tag, "_rv_drop"}, 8'(requestValid), 8'h00);
        n = 0;
        while (!cpuReady && n < 8) begin
            tick();
            n++;
        end
        check_val({tag, "_rdy"}, 8'(cpuReady), 8'h01);
        check_val({tag, "_rd"}, cpuRdData, exp_rd);
        cpuReq = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                  = 1'b1;
        cpuReq                 = 1'b0;
        cpuOp                  = 1'b0;
        cpuAddr                = 8'h00;
        cpuWrData              = 8'h00;
        fetchData              = 8'h00;
        fetchPresent           = 1'b0;
        interconnectionMessage = 3'b000;
        probeAddress           = 8'h00;
        tick();
        tick();
        check_val("rst_ready", 8'(cpuReady), 8'h00);
        check_val("rst_rv", 8'(requestValid), 8'h00);
        check_val("rst_wb", 8'(dataWriteBack), 8'h00);
        check_val("rst_addr", addressBypass, 8'h00);
        check_val("rst_rd", cpuRdData, 8'h00);
        reset = 1'b0;
        tick();

        // Cold read miss 0x04 -> GetS, fill 0x5A, line0 S.
        start(1'b0, 8'h04, 8'h00);
        tick();
        check_val("t1_rv", 8'(requestValid), 8'h01);
        check_val("t1_addr", addressBypass, 8'h04);
        check_val("t1_op", 8'(operationBypass), 8'h00);
        check_val("t1_wb", 8'(dataWriteBack), 8'h00);
        fill_and_finish("t1", 8'h5A, 8'h5A);
        hit_access("t1_hit", 1'b0, 8'h04, 8'h00, 8'h5A);

        // Stray fetchPresent while idle is ignored.
        fetchPresent = 1'b1;
        fetchData    = 8'hFF;
        tick();
        fetchPresent = 1'b0;
        check_val("stray_rdy", 8'(cpuReady), 8'h00);
        check_val("stray_rv", 8'(requestValid), 8'h00);

        // Write to S line -> GetM upgrade, ack data ignored, line0 M 0x11.
        start(1'b1, 8'h04, 8'h11);
        tick();
        check_val("t2_rv", 8'(requestValid), 8'h01);
        check_val("t2_op", 8'(operationBypass), 8'h01);
        check_val("t2_addr", addressBypass, 8'h04);
        fill_and_finish("t2", 8'hEE, 8'h11);
        hit_access("t2_rd", 1'b0, 8'h04, 8'h00, 8'h11);

        // Read 0x06 evicts M victim: writeback 0x04/0x11, then GetS 0x06.
        start(1'b0, 8'h06, 8'h00);
        tick();
        check_val("t3_wb", 8'(dataWriteBack), 8'h01);
        check_val("t3_wb_addr", addressBypass, 8'h04);
        check_val("t3_wb_data", dataBypass, 8'h11);
        check_val("t3_wb_rv", 8'(requestValid), 8'h00);
        tick();
        check_val("t3_wb_end", 8'(dataWriteBack), 8'h00);
        check_val("t3_rv", 8'(requestValid), 8'h01);
        check_val("t3_addr", addressBypass, 8'h06);
        check_val("t3_op", 8'(operationBypass), 8'h00);
        fill_and_finish("t3", 8'h77, 8'h77);

        // 0x04 now misses; S victim is dropped silently.
        start(1'b0, 8'h04, 8'h00);
        tick();
        check_val("t3b_rv", 8'(requestValid), 8'h01);
        check_val("t3b_wb", 8'(dataWriteBack), 8'h00);
        fill_and_finish("t3b", 8'h33, 8'h33);

        // Upgrade to M 0x22, then FETCH_INV probe: writeback next cycle, line invalid.
        start(1'b1, 8'h04, 8'h22);
        tick();
        check_val("t4u_op", 8'(operationBypass), 8'h01);
        fill_and_finish("t4u", 8'h00, 8'h22);
        probe(3'b011, 8'h04);
        check_val("t4_wb", 8'(dataWriteBack), 8'h01);
        check_val("t4_wb_addr", addressBypass, 8'h04);
        check_val("t4_wb_data", dataBypass, 8'h22);
        tick();
        check_val("t4_wb_end", 8'(dataWriteBack), 8'h00);
        start(1'b0, 8'h04, 8'h00);
        tick();
        check_val("t4r_rv", 8'(requestValid), 8'h01);
        check_val("t4r_wb", 8'(dataWriteBack), 8'h00);
        fill_and_finish("t4r", 8'h44, 8'h44);

        // Upgrade, write hit on M, FETCH probe downgrades to S with writeback of 0x66.
        start(1'b1, 8'h04, 8'h55);
        tick();
        check_val("t5u_rv", 8'(requestValid), 8'h01);
        fill_and_finish("t5u", 8'h00, 8'h55);
        hit_access("t5_wm", 1'b1, 8'h04, 8'h66, 8'h66);
        probe(3'b010, 8'h04);
        check_val("t5_wb", 8'(dataWriteBack), 8'h01);
        check_val("t5_wb_data", dataBypass, 8'h66);
        tick();
        hit_access("t5_rd", 1'b0, 8'h04, 8'h00, 8'h66);

        // Probe with a non-matching tag is ignored.
        probe(3'b011, 8'h06);
        check_val("t5_pmiss_wb", 8'(dataWriteBack), 8'h00);
        tick();
        hit_access("t5_pmiss_rd", 1'b0, 8'h04, 8'h00, 8'h66);

        // Line1 S, then INV to line1 during a line0 miss: requestValid stays up.
        start(1'b0, 8'h05, 8'h00);
        tick();
        check_val("t6a_addr", addressBypass, 8'h05);
        fill_and_finish("t6a", 8'h88, 8'h88);
        start(1'b0, 8'h06, 8'h00);
        tick();
        check_val("t6_rv0", 8'(requestValid), 8'h01);
        check_val("t6_addr", addressBypass, 8'h06);
        probe(3'b001, 8'h05);
        check_val("t6_rv1", 8'(requestValid), 8'h01);
        check_val("t6_wb", 8'(dataWriteBack), 8'h00);
        tick();
        check_val("t6_rv2", 8'(requestValid), 8'h01);
        fill_and_finish("t6b", 8'h99, 8'h99);
        start(1'b0, 8'h05, 8'h00);
        tick();
        check_val("t6_inv_rv", 8'(requestValid), 8'h01);
        check_val("t6_inv_addr", addressBypass, 8'h05);

        // Reset while the request is pending: outputs clear without a clock edge.
        #1;
        reset = 1'b1;
        #1;
        check_val("t7_rv", 8'(requestValid), 8'h00);
        check_val("t7_addr", addressBypass, 8'h00);
        check_val("t7_rdy", 8'(cpuReady), 8'h00);
        check_val("t7_wb", 8'(dataWriteBack), 8'h00);
        cpuReq = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        start(1'b0, 8'h06, 8'h00);
        tick();
        check_val("t7_miss_rv", 8'(requestValid), 8'h01);
        fill_and_finish("t7", 8'h12, 8'h12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
